nibble_serial_adder: RTL and testbench

Multi-cycle wide adder sequencer that sits directly around the team's 4-bit ripple-carry adder stage. It feeds that stage one nibble pair per cycle, consumes its sum nibble and carry-out, and chains the carry through a register. The result is a 4×NIBBLES-bit sum delivered over a valid/ready handshake. Wide addition reuses one 4-bit adder at the cost of NIBBLES cycles of latency.

---
 rtl/nibble_serial_adder.sv | 101 ++++++++++
 tb/tb_nibble_serial_adder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Wide adder sequencer around an external 4-bit ripple-carry stage: one nibble
// pair per cycle, carry chained through a register, result on valid/ready.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   out_ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     sum_sh;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     sum_next;

    // New sum nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
    assign sum_next = W'({add_sum, sum_sh} >> 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= in_b;
                        carry <= in_cin;
                        a_msb <= in_a[W-1];
                        b_msb <= in_b[W-1];
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= sum_next;
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    carry  <= add_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything below decodes registered state, so it is glitch-free and stable in DONE.
    assign in_ready  = (state == IDLE);
    assign add_a     = (state == RUN) ? a_sh[3:0] : 4'd0;
    assign add_b     = (state == RUN) ? b_sh[3:0] : 4'd0;
    assign add_cin   = (state == RUN) ? carry : 1'b0;
    assign out_valid = (state == DONE);
    assign out_sum   = out_valid ? sum_sh : '0;
    assign out_cout  = out_valid & carry;
    assign out_ovf   = out_valid && (a_msb == b_msb) && (sum_sh[W-1] != a_msb);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: NIBBLES=4 and NIBBLES=1 instances, each wrapped
// around a behavioural 4-bit adder, checked against plain wide arithmetic.
module tb_nibble_serial_adder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic        in_valid4, in_ready4, in_cin4, add_cin4, add_cout4;
    logic        out_valid4, out_ready4, out_cout4, out_ovf4;
    logic [15:0] in_a4, in_b4, out_sum4;
    logic [3:0]  add_a4, add_b4, add_sum4;

    logic        in_valid1, in_ready1, in_cin1, add_cin1, add_cout1;
    logic        out_valid1, out_ready1, out_cout1, out_ovf1;
    logic [3:0]  in_a1, in_b1, out_sum1;
    logic [3:0]  add_a1, add_b1, add_sum1;

    assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'd0, add_cin4};
    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'd0, add_cin1};

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_sum(out_sum4), .out_cout(out_cout4), .out_ovf(out_ovf4)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full NIBBLES=4 operation starting from IDLE at a negedge; stall = cycles out_ready held low in DONE.
    task automatic run_op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input int stall, input string tag);
        logic [16:0] exp_full;
        logic        exp_ovf;
        logic [3:0]  seen [4];
        int          lat;
        exp_full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        exp_ovf  = (a[15] == b[15]) && (exp_full[15] != a[15]);
        out_ready4 = 1'b0;
        in_a4 = a; in_b4 = b; in_cin4 = cin; in_valid4 = 1'b1;
        checks++;
        if (in_ready4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s accept_ready got %b want 1", tag, in_ready4);
        end
        step();
        in_valid4 = 1'b0;
        in_a4 = 16'($urandom); in_b4 = 16'($urandom); in_cin4 = 1'($urandom);
        lat = 0;
        while (out_valid4 !== 1'b1 && lat < 20) begin
            if (lat < 4) seen[lat] = add_a4;
            step();
            lat++;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("[TB] FAIL %s latency got %0d want 4", tag, lat);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (seen[j] !== a[4*j +: 4]) begin
                errors++;
                $display("[TB] FAIL %s add_a[%0d] got %h want %h", tag, j, seen[j], a[4*j +: 4]);
            end
        end
        for (int s = 0; s <= stall; s++) begin
            checks++;
            if (out_valid4 !== 1'b1 || out_sum4 !== exp_full[15:0] ||
                out_cout4 !== exp_full[16] || out_ovf4 !== exp_ovf) begin
                errors++;
                $display("[TB] FAIL %s result cyc%0d got v=%b sum=%h cout=%b ovf=%b want v=1 sum=%h cout=%b ovf=%b",
                         tag, s, out_valid4, out_sum4, out_cout4, out_ovf4,
                         exp_full[15:0], exp_full[16], exp_ovf);
            end
            checks++;
            if (in_ready4 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s done_in_ready got %b want 0", tag, in_ready4);
            end
            if (s == stall) break;
            in_valid4 = 1'($urandom);
            in_a4 = 16'($urandom); in_b4 = 16'($urandom);
            step();
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s release got v=%b rdy=%b want v=0 rdy=1", tag, out_valid4, in_ready4);
        end
    endtask

    task automatic run_op1(input logic [3:0] a, input logic [3:0] b, input logic cin, input string tag);
        logic [4:0] exp_full;
        logic       exp_ovf;
        logic [3:0] seen;
        int         lat;
        exp_full = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        exp_ovf  = (a[3] == b[3]) && (exp_full[3] != a[3]);
        out_ready1 = 1'b0;
        in_a1 = a; in_b1 = b; in_cin1 = cin; in_valid1 = 1'b1;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s accept_ready got %b want 1", tag, in_ready1);
        end
        step();
        in_valid1 = 1'b0;
        seen = add_a1;
        lat = 0;
        while (out_valid1 !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        checks++;
        if (lat != 1 || seen !== a) begin
            errors++;
            $display("[TB] FAIL %s run got lat=%0d add_a=%h want lat=1 add_a=%h", tag, lat, seen, a);
        end
        checks++;
        if (out_sum1 !== exp_full[3:0] || out_cout1 !== exp_full[4] || out_ovf1 !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL %s result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     tag, out_sum1, out_cout1, out_ovf1, exp_full[3:0], exp_full[4], exp_ovf);
        end
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s release got v=%b rdy=%b want v=0 rdy=1", tag, out_valid1, in_ready1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid4 = 1'($urandom); out_ready4 = 1'($urandom);
            in_a4 = 16'($urandom); in_b4 = 16'($urandom); in_cin4 = 1'($urandom);
            step();
            checks++;
            if (out_valid4 !== 1'b0 || out_sum4 !== 16'h0 || out_cout4 !== 1'b0 || out_ovf4 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_out got v=%b sum=%h cout=%b ovf=%b want all 0",
                         out_valid4, out_sum4, out_cout4, out_ovf4);
            end
            checks++;
            if (add_a4 !== 4'h0 || add_b4 !== 4'h0 || add_cin4 !== 1'b0 || in_ready4 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_add got a=%h b=%h cin=%b rdy=%b want 0 0 0 1",
                         add_a4, add_b4, add_cin4, in_ready4);
            end
        end
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_n1 got v=%b rdy=%b want v=0 rdy=1", out_valid1, in_ready1);
        end
        in_valid4 = 1'b0; out_ready4 = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release got rdy=%b v=%b want rdy=1 v=0", in_ready4, out_valid4);
        end
    endtask

    task automatic test_no_carry();
        run_op4(16'h1234, 16'h4321, 1'b0, 0, "no_carry");
    endtask

    task automatic test_full_ripple();
        run_op4(16'hFFFF, 16'h0001, 1'b0, 0, "ripple_ffff");
        run_op4(16'h0000, 16'h0000, 1'b1, 0, "ripple_cin");
    endtask

    task automatic test_overflow();
        run_op4(16'h7FFF, 16'h0001, 1'b0, 0, "ovf_pos");
        run_op4(16'h8000, 16'h8000, 1'b0, 0, "ovf_neg");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_op4(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_backpressure();
        run_op4(16'hA5C3, 16'h3C5A, 1'b1, 5, "backpressure");
        run_op4(16'h0102, 16'h0304, 1'b0, 0, "after_bp");
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_q [$];
        int          acc_cyc [$];
        logic [17:0] e;
        logic [16:0] full;
        out_ready4 = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid4 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_extra got sum=%h want no result", out_sum4);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_ovf4, out_cout4, out_sum4} !== e) begin
                        errors++;
                        $display("[TB] FAIL b2b_result got %h want %h", {out_ovf4, out_cout4, out_sum4}, e);
                    end
                end
            end
            in_valid4 = (cyc < 30);
            in_a4 = 16'($urandom); in_b4 = 16'($urandom); in_cin4 = 1'($urandom);
            if (in_valid4 && in_ready4) begin
                full = {1'b0, in_a4} + {1'b0, in_b4} + {16'd0, in_cin4};
                exp_q.push_back({(in_a4[15] == in_b4[15]) && (full[15] != in_a4[15]), full});
                acc_cyc.push_back(cyc);
            end
            step();
        end
        out_ready4 = 1'b0;
        in_valid4  = 1'b0;
        checks++;
        if (exp_q.size() != 0 || acc_cyc.size() != 5) begin
            errors++;
            $display("[TB] FAIL b2b_count got pending=%0d accepts=%0d want 0 and 5", exp_q.size(), acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
                errors++;
                $display("[TB] FAIL b2b_interval got %0d want 6", acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bit saw_valid;
        in_a4 = 16'h1234; in_b4 = 16'h1111; in_cin4 = 1'b0; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || add_a4 !== 4'h0) begin
            errors++;
            $display("[TB] FAIL midop_reset got v=%b rdy=%b add_a=%h want 0 1 0", out_valid4, in_ready4, add_a4);
        end
        step();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid4 !== 1'b0) saw_valid = 1'b1;
            step();
        end
        checks++;
        if (saw_valid || in_ready4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midop_abort got saw_valid=%b rdy=%b want 0 1", saw_valid, in_ready4);
        end
        run_op4(16'h00FF, 16'h0001, 1'b0, 0, "post_reset");
    endtask

    task automatic test_nibble1();
        in_a1 = 4'h9; in_b1 = 4'h9; in_cin1 = 1'b0; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL n1_midop_reset got v=%b rdy=%b want 0 1", out_valid1, in_ready1);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL n1_abort got v=%b want 0", out_valid1);
        end
        run_op1(4'hF, 4'h1, 1'b0, "n1_wrap");
        run_op1(4'h7, 4'h1, 1'b0, "n1_ovf");
        for (int i = 0; i < 4; i++) begin
            run_op1(4'($urandom), 4'($urandom), 1'($urandom), "n1_random");
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        checks = 0;
        errors = 0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; in_a4 = '0; in_b4 = '0; in_cin4 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_no_carry();
        test_full_ripple();
        test_overflow();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_nibble1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
